pkt_rr_arbiter: RTL and testbench

- Packet-granular arbiter that shares one downstream packet path (e.g. the GPP input) among N requesters. Each requester has at least one complete packet buffered; N is typically 2–4.
- Two priority classes:
  - round-robin within each class;
  - strict high-over-low between classes, with an anti-starvation quota for the low class.
- Sits in front of the source FIFOs. It drives their read enables through the grant vector and releases the grant on end-of-packet from the datapath.
- Includes a hang watchdog and per-requester grant counters for debug and statistics.

---
 rtl/pkt_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rr_arbiter.sv
// Packet-granular arbiter with two priority classes, round-robin within each class,
// an anti-starvation quota for the low class, a hang watchdog and grant counters.
module pkt_rr_arbiter #(
    parameter int N            = 4,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 2048,
    parameter int TW           = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic [N-1:0] prio_hi,
    input  logic         dst_alf,
    input  logic         pkt_done,
    output logic [N-1:0] grant,
    output logic [2:0]   grant_idx,
    output logic         grant_vld,
    output logic         timeout_err,
    input  logic [2:0]   cnt_sel,
    output logic [31:0]  cnt_rdata,
    input  logic         cnt_clr
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [2:0]    grant_idx_q, grant_idx_d;
    logic [2:0]    ptr_hi_q, ptr_hi_d;
    logic [2:0]    ptr_lo_q, ptr_lo_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   cnt_q [N];
    logic [31:0]   cnt_d [N];
    logic [31:0]   cnt_rdata_q, cnt_rdata_d;

    logic [N-1:0]  h_req, l_req;
    logic [3:0]    pick_hi, pick_lo;
    logic          use_lo;
    logic          issue;
    logic [2:0]    win;

    // Returns {found, index} of the first set bit at or above ptr, wrapping at N.
    function automatic logic [3:0] rr_pick(input logic [N-1:0] mask, input logic [2:0] ptr);
        logic [3:0] res;
        logic [3:0] idx;
        logic [7:0] mask8;
        res   = '0;
        mask8 = 8'(mask);
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(N)) begin
                idx = idx - 4'(N);
            end
            if (mask8[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        return (idx == 3'(N - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    always_comb begin
        h_req   = req & prio_hi;
        l_req   = req & ~prio_hi;
        pick_hi = rr_pick(h_req, ptr_hi_q);
        pick_lo = rr_pick(l_req, ptr_lo_q);
        use_lo  = pick_lo[3] && (!pick_hi[3] || (starve_q == SW'(STARVE_LIMIT)));
        win     = use_lo ? pick_lo[2:0] : pick_hi[2:0];
        issue   = (state_q == IDLE) && !dst_alf && (pick_hi[3] || pick_lo[3]);
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        ptr_hi_d      = ptr_hi_q;
        ptr_lo_d      = ptr_lo_q;
        starve_d      = starve_q;
        timer_d       = timer_q;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d     = BUSY;
                    grant_d     = {{(N-1){1'b0}}, 1'b1} << win;
                    grant_idx_d = win;
                    timer_d     = '0;
                    if (use_lo) begin
                        ptr_lo_d = wrap_inc(win);
                    end else begin
                        ptr_hi_d = wrap_inc(win);
                    end
                    // The quota only accumulates while a low-class packet is actually waiting.
                    if (!use_lo && pick_lo[3]) begin
                        starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                end
            end
            BUSY: begin
                timer_d = timer_q + TW'(1);
                if (pkt_done || (timer_q == TW'(TIMEOUT - 1))) begin
                    state_d       = IDLE;
                    grant_d       = '0;
                    grant_idx_d   = '0;
                    timeout_err_d = !pkt_done;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear coinciding with a grant wins, so that grant goes uncounted.
    always_comb begin
        cnt_rdata_d = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (issue && (win == 3'(i))) begin
                cnt_d[i] = cnt_q[i] + 32'd1;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            if (cnt_sel == 3'(i)) begin
                cnt_rdata_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            ptr_hi_q      <= '0;
            ptr_lo_q      <= '0;
            starve_q      <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
            cnt_rdata_q   <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            ptr_hi_q      <= ptr_hi_d;
            ptr_lo_q      <= ptr_lo_d;
            starve_q      <= starve_d;
            timer_q       <= timer_d;
            timeout_err_q <= timeout_err_d;
            cnt_rdata_q   <= cnt_rdata_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_vld   = (state_q == BUSY);
    assign timeout_err = timeout_err_q;
    assign cnt_rdata   = cnt_rdata_q;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Scoreboard bench for pkt_rr_arbiter: expected winners are queued by the stimulus
// and popped by a monitor on every new grant; other checks are directed.
module tb_pkt_rr_arbiter;
    localparam int N            = 4;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 16;
    localparam int TW           = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] req;
    logic [N-1:0] prio_hi;
    logic         dst_alf;
    logic         pkt_done;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         grant_vld;
    logic         timeout_err;
    logic [2:0]   cnt_sel;
    logic [31:0]  cnt_rdata;
    logic         cnt_clr;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int exp_cnt[N];
    int terr_seen = 0;

    pkt_rr_arbiter #(
        .N(N), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .prio_hi(prio_hi), .dst_alf(dst_alf),
        .pkt_done(pkt_done), .grant(grant), .grant_idx(grant_idx), .grant_vld(grant_vld),
        .timeout_err(timeout_err), .cnt_sel(cnt_sel), .cnt_rdata(cnt_rdata), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] p, input logic alf);
        req     = r;
        prio_hi = p;
        dst_alf = alf;
    endtask

    task automatic expectGrant(input int idx);
        exp_q.push_back(idx);
        exp_cnt[idx]++;
    endtask

    task automatic monitorGrants();
        logic prev = 1'b0;
        int   e;
        forever begin
            @(negedge clk);
            if (timeout_err) terr_seen++;
            if (grant_vld && !prev) begin
                checkOutput("grant_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("grant_idx", 32'(grant_idx), 32'(e));
                    checkOutput("grant_onehot", 32'(grant), 32'd1 << e);
                end
            end
            prev = grant_vld;
        end
    endtask

    task automatic waitGrant(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (grant_vld) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("wait_grant", 32'(ok), 32'd1);
    endtask

    task automatic runPacket(input int hold, input logic [N-1:0] req_after);
        bit ok;
        waitGrant(ok);
        if (ok) begin
            repeat (hold - 1) @(negedge clk);
            pkt_done = 1'b1;
            req      = req_after;
            @(negedge clk);
            pkt_done = 1'b0;
            checkOutput("release_gap", 32'(grant_vld), 32'd0);
        end
    endtask

    task automatic readCnt(input int sel, input int expected, input string name);
        cnt_sel = 3'(sel);
        @(negedge clk);
        checkOutput(name, cnt_rdata, 32'(expected));
    endtask

    task automatic doReset();
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        rst_n    = 1'b0;
        pkt_done = 1'b0;
        cnt_clr  = 1'b0;
        applyStimulus('0, '0, 1'b0);
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        bit ok;
        int t0;
        bit held_ok;
        applyStimulus('0, '0, 1'b0);
        pkt_done = 1'b0;
        cnt_sel  = 3'd0;
        cnt_clr  = 1'b0;
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        fork
            monitorGrants();
        join_none

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_grant_idx", 32'(grant_idx), 32'd0);
        checkOutput("rst_grant_vld", 32'(grant_vld), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_cnt_rdata", cnt_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] round robin, all low class");
        expectGrant(0); expectGrant(1); expectGrant(2); expectGrant(3); expectGrant(0);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) runPacket(3, 4'b1111);
        runPacket(3, 4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("rr_idle_after", 32'(grant_vld), 32'd0);
        for (int i = 0; i < N; i++) readCnt(i, exp_cnt[i], "rr_counter");
        readCnt(5, 0, "cnt_sel_out_of_range");

        $display("[TB] starvation quota");
        doReset();
        for (int i = 0; i < 2; i++) begin
            expectGrant(0); expectGrant(0); expectGrant(0); expectGrant(0); expectGrant(1);
        end
        applyStimulus(4'b0011, 4'b0001, 1'b0);
        for (int i = 0; i < 9; i++) runPacket(1, 4'b0011);
        runPacket(1, 4'b0000);
        readCnt(0, exp_cnt[0], "starve_cnt0");
        readCnt(1, exp_cnt[1], "starve_cnt1");

        $display("[TB] downstream almost-full");
        doReset();
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (grant_vld) held_ok = 1'b0;
        end
        checkOutput("alf_blocks_grant", 32'(held_ok), 32'd1);
        expectGrant(2);
        dst_alf = 1'b0;
        @(negedge clk);
        checkOutput("alf_release_grant", 32'(grant), 32'h4);
        checkOutput("alf_release_idx", 32'(grant_idx), 32'd2);
        applyStimulus(4'b0001, 4'b0000, 1'b1);
        held_ok = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (grant !== 4'b0100 || !grant_vld) held_ok = 1'b0;
        end
        checkOutput("grant_held_midpkt", 32'(held_ok), 32'd1);
        pkt_done = 1'b1;
        req      = 4'b0000;
        @(negedge clk);
        pkt_done = 1'b0;
        checkOutput("alf_pkt_release", 32'(grant_vld), 32'd0);
        dst_alf = 1'b0;

        $display("[TB] watchdog");
        doReset();
        t0 = terr_seen;
        expectGrant(0);
        expectGrant(1);
        applyStimulus(4'b0011, 4'b0000, 1'b0);
        waitGrant(ok);
        held_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (!grant_vld || timeout_err) held_ok = 1'b0;
        end
        checkOutput("wd_hold_16", 32'(held_ok), 32'd1);
        @(negedge clk);
        checkOutput("wd_release", 32'(grant_vld), 32'd0);
        checkOutput("wd_err_pulse", 32'(timeout_err), 32'd1);
        waitGrant(ok);
        req = 4'b0000;
        checkOutput("wd_err_one_cycle", 32'(timeout_err), 32'd0);
        repeat (15) @(negedge clk);
        checkOutput("wd_still_held", 32'(grant_vld), 32'd1);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        checkOutput("wd_done_release", 32'(grant_vld), 32'd0);
        checkOutput("wd_done_no_err", 32'(timeout_err), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("wd_err_count", 32'(terr_seen - t0), 32'd1);

        $display("[TB] counter clear on grant cycle");
        readCnt(0, exp_cnt[0], "pre_clr_cnt0");
        readCnt(1, exp_cnt[1], "pre_clr_cnt1");
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        exp_q.push_back(3);
        applyStimulus(4'b1000, 4'b0000, 1'b0);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        runPacket(1, 4'b0000);
        for (int i = 0; i < N; i++) readCnt(i, 0, "clr_counter");
        expectGrant(3);
        req = 4'b1000;
        runPacket(1, 4'b0000);
        readCnt(3, exp_cnt[3], "post_clr_count");

        $display("[TB] reset mid-packet");
        expectGrant(1);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        waitGrant(ok);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_grant", 32'(grant), 32'd0);
        checkOutput("midrst_grant_vld", 32'(grant_vld), 32'd0);
        checkOutput("midrst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("midrst_cnt_rdata", cnt_rdata, 32'd0);
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        @(negedge clk);
        req = 4'b1000;
        expectGrant(3);
        @(negedge clk);
        rst_n = 1'b1;
        runPacket(1, 4'b0000);
        readCnt(3, exp_cnt[3], "midrst_cnt3");
        readCnt(1, exp_cnt[1], "midrst_cnt1");

        repeat (3) @(negedge clk);
        checkOutput("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
